any1_rob: RTL and testbench
===========================

// Module: any1_rob
// PURPOSE
// Reorder buffer: receiving end of the execute-stage result interface (sExecuteOut). Decode allocates
// entries in program order and gets a rid back. Execute writes results back out of order, by rid.
// The buffer retires entries in order, one per cycle, to register-file write and exception logic.
// PARAMETERS
// ROB_ENTRIES  16   entry count; must equal 2**$bits(rid) (rid is 4 bits)
// AWID         32   instruction address width (pkg AWID)
// PORTS
// clk_i           in   1      clock
// rst_ni          in   1      asynchronous active-low reset
// flush_i         in   1      discard all entries (branch mispredict/epoch change)
// epoch_i         in   6      current epoch; writebacks with a different epoch are dropped
// alloc_v_i       in   1      allocate request from decode
// alloc_ip_i      in   AWID   instruction address
// alloc_rfwr_i    in   1      instruction writes the register file
// alloc_Rt_i      in   8      target register
// alloc_rdy_o     out  1      not full; allocate accepted this cycle when alloc_v_i & alloc_rdy_o
// alloc_rid_o     out  4      rid assigned to an accepted allocation (= tail pointer)
// wb_v_i          in   1      execute result valid
// wb_i            in   sExecuteOut  result: epoch, rid, res, rfwr, Rt
// wb_ii_i         in   1      illegal instruction
// wb_cause_i      in   16     fault cause; FLT_NONE = none
// wb_jump_i/wb_branch_i/wb_takb_i  in 1 each  control-flow flags
// wb_jump_tgt_i   in   64     jump target
// cmt_v_o         out  1      one-cycle retire pulse
// cmt_rid_o       out  4      retired rid
// cmt_ip_o        out  AWID   retired instruction address
// rf_we_o         out  1      register write (cmt_v_o & rfwr & no fault)
// rf_Rt_o/rf_res_o out 8/64   write target / data
// exc_o           out  1      one-cycle fault pulse at retire
// exc_cause_o     out  16     fault cause (FLT_UNIMP when ii)
// count_o         out  5      occupied entries; empty_o/full_o out 1 each
// BEHAVIOUR
// - Reset (async, rst_ni=0) and flush_i: head=tail=0, count=0, all entry v=0.
//   All outputs 0; empty_o=1, alloc_rdy_o=1.
// - flush_i has priority over alloc, writeback and commit in the same cycle.
//   The registered commit/exc outputs are cleared on that edge.
// - Storage: array of sReorderEntry indexed by rid; head and tail wrap mod ROB_ENTRIES.
// - Alloc: when alloc_v_i & !full, entry[tail] is written: v=1, cmt=0, ip, rfwr, Rt; cause=FLT_NONE.
//   tail++ and count++ follow. alloc_rid_o shows the pre-increment tail.
//   full_o is computed from count at cycle start, so alloc is blocked when full even if a commit
//   occurs the same cycle.
// - Writeback: when wb_v_i & entry[rid].v & !entry[rid].cmt & wb_i.epoch==epoch_i, the entry gets
//   cmt=1, res, ii, cause, jump, jump_tgt, branch and takb. Otherwise the writeback is ignored
//   (stale, duplicate or unallocated).
// - Commit (registered): on an edge where entry[head].v & entry[head].cmt:
//   - cmt_v_o<=1; cmt_rid_o, cmt_ip_o, rf_Rt_o, rf_res_o <= head fields;
//   - entry[head].v<=0; head++; count--.
//   Latency: writeback accepted at edge k -> cmt_v_o high after edge k+1.
//   Maximum one retire per cycle. Pulse outputs return to 0 the next cycle unless another retire occurs.
// - Fault at commit (ii or cause!=FLT_NONE):
//   - rf_we_o=0, exc_o=1, exc_cause_o=(ii ? FLT_UNIMP : cause);
//   - the whole buffer is flushed on the same edge, as for flush_i; any alloc that edge is dropped.
// - Alloc and commit on the same edge: count is unchanged, and both pointers advance.
// - Writeback and commit to the same (head) entry on the same edge: commit sees the old cmt=0 and
//   retires on the next edge.
// - Wrap: rid 15 -> 0. After 16 allocations with no commits, full_o=1 and alloc_rdy_o=0.
// STRUCTURE
// - any1_pkg: reuse sReorderEntry, sExecuteOut, FLT_NONE, FLT_UNIMP.
// - any1_pkg additions: parameter ROB_ENTRIES=16 and typedef logic [3:0] RobId.
// - No sub-module: pointers, count and the entry array live in any1_rob.
// TESTING
// 1 Reset mid-stream: 5 allocs, then rst_ni=0 -> count_o=0, empty_o=1, cmt_v_o=0; next alloc returns rid 0.
// 2 In order: alloc rid0..2 (Rt 1,2,3); writeback rid0 res=64'h11 -> one edge later cmt_v_o=1,
//   rf_we_o=1, Rt=1, res=64'h11, count_o=2.
// 3 Out of order: writebacks rid2, rid1, rid0 -> three consecutive commits, rid 0,1,2, with no gaps.
// 4 Full/wrap: 16 allocs -> full_o=1, 17th not accepted. Commit one, alloc one -> rid 0 reused,
//   count_o=16.
// 5 Fault: rid1 written back with wb_ii_i=1, rids 0 and 2 done ->
//   - rid0 commits;
//   - then exc_o=1, exc_cause_o=8'h37, rf_we_o=0;
//   - count_o=0 and rid2 is never committed.
// 6 Stale and flush: writeback with epoch_i-1 is ignored (no commit). flush_i together with
//   alloc_v_i -> count_o=0 and the alloc is dropped.

Source files
------------

// File: rtl/any1_pkg.sv
// Shared types for the any1 core: execute-stage result bundle, reorder-buffer entry and fault codes.
package any1_pkg;

   parameter int AWID        = 32;
   parameter int ROB_ENTRIES = 16;

   typedef logic [3:0] RobId;

   localparam logic [15:0] FLT_NONE  = 16'h0000;
   localparam logic [15:0] FLT_UNIMP = 16'h0037;

   typedef struct packed {
      logic [5:0]  epoch;
      RobId        rid;
      logic [63:0] res;
      logic        rfwr;
      logic [7:0]  Rt;
   } sExecuteOut;

   typedef struct packed {
      logic            v;
      logic            cmt;
      logic [AWID-1:0] ip;
      logic            rfwr;
      logic [7:0]      Rt;
      logic [63:0]     res;
      logic            ii;
      logic [15:0]     cause;
      logic            jump;
      logic [63:0]     jump_tgt;
      logic            branch;
      logic            takb;
   } sReorderEntry;

endpackage

// File: rtl/any1_rob.sv
// Reorder buffer: in-order allocate from decode, out-of-order writeback by rid,
// in-order retire of one entry per cycle with fault-triggered flush.
module any1_rob
   import any1_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic [5:0]       epoch_i,
   input  logic             alloc_v_i,
   input  logic [AWID-1:0]  alloc_ip_i,
   input  logic             alloc_rfwr_i,
   input  logic [7:0]       alloc_Rt_i,
   output logic             alloc_rdy_o,
   output logic [3:0]       alloc_rid_o,
   input  logic             wb_v_i,
   input  sExecuteOut       wb_i,
   input  logic             wb_ii_i,
   input  logic [15:0]      wb_cause_i,
   input  logic             wb_jump_i,
   input  logic             wb_branch_i,
   input  logic             wb_takb_i,
   input  logic [63:0]      wb_jump_tgt_i,
   output logic             cmt_v_o,
   output logic [3:0]       cmt_rid_o,
   output logic [AWID-1:0]  cmt_ip_o,
   output logic             rf_we_o,
   output logic [7:0]       rf_Rt_o,
   output logic [63:0]      rf_res_o,
   output logic             exc_o,
   output logic [15:0]      exc_cause_o,
   output logic [4:0]       count_o,
   output logic             empty_o,
   output logic             full_o
);

   sReorderEntry entry_reg [ROB_ENTRIES];
   RobId         head_reg;
   RobId         tail_reg;
   logic [4:0]   count_reg;

   sReorderEntry head_ent;
   logic         full;
   logic         do_alloc;
   logic         do_commit;
   logic         commit_fault;
   logic         clear_all;
   logic         wb_ok;

   assign head_ent     = entry_reg[head_reg];
   assign full         = (count_reg == 5'(ROB_ENTRIES));
   assign do_alloc     = alloc_v_i & ~full;
   assign do_commit    = head_ent.v & head_ent.cmt;
   assign commit_fault = do_commit & (head_ent.ii | (head_ent.cause != FLT_NONE));
   assign clear_all    = flush_i | commit_fault;
   // Stale-epoch, duplicate and unallocated writebacks all fall out here.
   assign wb_ok        = wb_v_i & entry_reg[wb_i.rid].v & ~entry_reg[wb_i.rid].cmt
                         & (wb_i.epoch == epoch_i);

   assign count_o     = count_reg;
   assign empty_o     = (count_reg == 5'd0);
   assign full_o      = full;
   assign alloc_rdy_o = ~full;
   assign alloc_rid_o = tail_reg;

   // Control-flow fields are carried for downstream consumers; the register target and
   // write-enable come from the allocation, not from the writeback.
   logic unused_fields;
   assign unused_fields = &{1'b0, wb_i.rfwr, wb_i.Rt, head_ent.jump, head_ent.jump_tgt,
                            head_ent.branch, head_ent.takb};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else if (clear_all) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (do_alloc)
            tail_reg <= tail_reg + 4'd1;
         if (do_commit)
            head_reg <= head_reg + 4'd1;
         count_reg <= count_reg + 5'(do_alloc) - 5'(do_commit);
      end
   end

   // Alloc (tail), writeback (allocated, uncommitted) and retire (head, committed) never
   // touch the same slot on one edge, so their writes are independent.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < ROB_ENTRIES; i++)
            entry_reg[i] <= '0;
      end else if (clear_all) begin
         for (int i = 0; i < ROB_ENTRIES; i++) begin
            entry_reg[i].v   <= 1'b0;
            entry_reg[i].cmt <= 1'b0;
         end
      end else begin
         if (do_alloc) begin
            entry_reg[tail_reg].v     <= 1'b1;
            entry_reg[tail_reg].cmt   <= 1'b0;
            entry_reg[tail_reg].ip    <= alloc_ip_i;
            entry_reg[tail_reg].rfwr  <= alloc_rfwr_i;
            entry_reg[tail_reg].Rt    <= alloc_Rt_i;
            entry_reg[tail_reg].ii    <= 1'b0;
            entry_reg[tail_reg].cause <= FLT_NONE;
         end
         if (wb_ok) begin
            entry_reg[wb_i.rid].cmt      <= 1'b1;
            entry_reg[wb_i.rid].res      <= wb_i.res;
            entry_reg[wb_i.rid].ii       <= wb_ii_i;
            entry_reg[wb_i.rid].cause    <= wb_cause_i;
            entry_reg[wb_i.rid].jump     <= wb_jump_i;
            entry_reg[wb_i.rid].jump_tgt <= wb_jump_tgt_i;
            entry_reg[wb_i.rid].branch   <= wb_branch_i;
            entry_reg[wb_i.rid].takb     <= wb_takb_i;
         end
         if (do_commit)
            entry_reg[head_reg].v <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cmt_v_o     <= 1'b0;
         cmt_rid_o   <= '0;
         cmt_ip_o    <= '0;
         rf_we_o     <= 1'b0;
         rf_Rt_o     <= '0;
         rf_res_o    <= '0;
         exc_o       <= 1'b0;
         exc_cause_o <= '0;
      end else if (flush_i) begin
         cmt_v_o     <= 1'b0;
         cmt_rid_o   <= '0;
         cmt_ip_o    <= '0;
         rf_we_o     <= 1'b0;
         rf_Rt_o     <= '0;
         rf_res_o    <= '0;
         exc_o       <= 1'b0;
         exc_cause_o <= '0;
      end else begin
         cmt_v_o     <= do_commit;
         rf_we_o     <= do_commit & head_ent.rfwr & ~commit_fault;
         exc_o       <= commit_fault;
         exc_cause_o <= commit_fault ? (head_ent.ii ? FLT_UNIMP : head_ent.cause) : FLT_NONE;
         if (do_commit) begin
            cmt_rid_o <= head_reg;
            cmt_ip_o  <= head_ent.ip;
            rf_Rt_o   <= head_ent.Rt;
            rf_res_o  <= head_ent.res;
         end
      end
   end

endmodule

// File: tb/tb_any1_rob.sv
// Self-checking bench for any1_rob: directed scenarios plus random traffic against a queue model.
module tb_any1_rob;
   import any1_pkg::*;

   logic             clk;
   logic             rst_ni;
   logic             flush;
   logic [5:0]       epoch;
   logic             alloc_v;
   logic [AWID-1:0]  alloc_ip;
   logic             alloc_rfwr;
   logic [7:0]       alloc_Rt;
   logic             alloc_rdy;
   logic [3:0]       alloc_rid;
   logic             wb_v;
   sExecuteOut       wb;
   logic             wb_ii;
   logic [15:0]      wb_cause;
   logic             wb_jump, wb_branch, wb_takb;
   logic [63:0]      wb_jump_tgt;
   logic             cmt_v;
   logic [3:0]       cmt_rid;
   logic [AWID-1:0]  cmt_ip;
   logic             rf_we;
   logic [7:0]       rf_Rt;
   logic [63:0]      rf_res;
   logic             exc;
   logic [15:0]      exc_cause;
   logic [4:0]       count;
   logic             empty, full;

   int checks = 0;
   int errors = 0;

   any1_rob dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .epoch_i(epoch),
      .alloc_v_i(alloc_v), .alloc_ip_i(alloc_ip), .alloc_rfwr_i(alloc_rfwr), .alloc_Rt_i(alloc_Rt),
      .alloc_rdy_o(alloc_rdy), .alloc_rid_o(alloc_rid),
      .wb_v_i(wb_v), .wb_i(wb), .wb_ii_i(wb_ii), .wb_cause_i(wb_cause),
      .wb_jump_i(wb_jump), .wb_branch_i(wb_branch), .wb_takb_i(wb_takb), .wb_jump_tgt_i(wb_jump_tgt),
      .cmt_v_o(cmt_v), .cmt_rid_o(cmt_rid), .cmt_ip_o(cmt_ip),
      .rf_we_o(rf_we), .rf_Rt_o(rf_Rt), .rf_res_o(rf_res),
      .exc_o(exc), .exc_cause_o(exc_cause),
      .count_o(count), .empty_o(empty), .full_o(full)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: queue of in-flight instructions, oldest first.
   typedef struct {
      logic [3:0]  rid;
      logic [31:0] ip;
      logic        rfwr;
      logic [7:0]  Rt;
      bit          done;
      logic [63:0] res;
      logic        ii;
      logic [15:0] cause;
   } ment_t;

   ment_t       mq[$];
   int          m_tail;
   logic        e_cmt_v, e_rf_we, e_exc;
   logic [3:0]  e_cmt_rid;
   logic [31:0] e_cmt_ip;
   logic [7:0]  e_rf_Rt;
   logic [63:0] e_rf_res;
   logic [15:0] e_exc_cause;

   task automatic model_reset();
      mq.delete();
      m_tail = 0;
      e_cmt_v = 0; e_rf_we = 0; e_exc = 0; e_cmt_rid = 0; e_cmt_ip = 0;
      e_rf_Rt = 0; e_rf_res = 0; e_exc_cause = 0;
   endtask

   task automatic model_step();
      bit    is_full, com, flt;
      ment_t h, n;
      if (flush) begin
         model_reset();
         return;
      end
      is_full = (mq.size() == 16);
      com     = (mq.size() > 0) && mq[0].done;
      flt     = 0;
      e_cmt_v = 0; e_rf_we = 0; e_exc = 0; e_exc_cause = 16'h0;
      if (com) begin
         h = mq[0];
         flt = h.ii || (h.cause != 16'h0);
         e_cmt_v = 1; e_cmt_rid = h.rid; e_cmt_ip = h.ip; e_rf_Rt = h.Rt; e_rf_res = h.res;
         e_rf_we = h.rfwr && !flt;
         e_exc = flt;
         e_exc_cause = flt ? (h.ii ? 16'h0037 : h.cause) : 16'h0;
      end
      if (wb_v && wb.epoch == epoch) begin
         for (int j = 0; j < mq.size(); j++) begin
            if (mq[j].rid == wb.rid && !mq[j].done) begin
               mq[j].done = 1; mq[j].res = wb.res; mq[j].ii = wb_ii; mq[j].cause = wb_cause;
               break;
            end
         end
      end
      if (flt) begin
         mq.delete();
         m_tail = 0;
      end else begin
         if (com) void'(mq.pop_front());
         if (alloc_v && !is_full) begin
            n.rid = 4'(m_tail); n.ip = alloc_ip; n.rfwr = alloc_rfwr; n.Rt = alloc_Rt;
            n.done = 0; n.res = 0; n.ii = 0; n.cause = 0;
            mq.push_back(n);
            m_tail = (m_tail + 1) % 16;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all();
      chk("count", 64'(count), 64'(mq.size()));
      chk("empty", 64'(empty), 64'(mq.size() == 0));
      chk("full", 64'(full), 64'(mq.size() == 16));
      chk("alloc_rdy", 64'(alloc_rdy), 64'(mq.size() != 16));
      chk("alloc_rid", 64'(alloc_rid), 64'(m_tail));
      chk("cmt_v", 64'(cmt_v), 64'(e_cmt_v));
      chk("cmt_rid", 64'(cmt_rid), 64'(e_cmt_rid));
      chk("cmt_ip", 64'(cmt_ip), 64'(e_cmt_ip));
      chk("rf_we", 64'(rf_we), 64'(e_rf_we));
      chk("rf_Rt", 64'(rf_Rt), 64'(e_rf_Rt));
      chk("rf_res", rf_res, e_rf_res);
      chk("exc", 64'(exc), 64'(e_exc));
      chk("exc_cause", 64'(exc_cause), 64'(e_exc_cause));
   endtask

   task automatic idle_inputs();
      flush = 0; alloc_v = 0; alloc_ip = '0; alloc_rfwr = 0; alloc_Rt = '0;
      wb_v = 0; wb = '0; wb_ii = 0; wb_cause = 16'h0;
      wb_jump = 0; wb_branch = 0; wb_takb = 0; wb_jump_tgt = '0;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic idle1();
      idle_inputs();
      cycle();
   endtask

   task automatic flush1();
      idle_inputs();
      flush = 1;
      cycle();
      idle_inputs();
   endtask

   task automatic alloc1(input logic [7:0] rt, input logic rfwr);
      idle_inputs();
      alloc_v = 1; alloc_ip = $urandom; alloc_Rt = rt; alloc_rfwr = rfwr;
      cycle();
      idle_inputs();
   endtask

   task automatic wb1(input logic [3:0] rid, input logic [63:0] res, input logic ii, input logic stale);
      idle_inputs();
      wb_v = 1; wb.rid = rid; wb.res = res; wb.rfwr = 1; wb.Rt = 8'h0;
      wb.epoch = stale ? epoch - 6'd1 : epoch;
      wb_ii = ii;
      cycle();
      idle_inputs();
   endtask

   initial begin
      int pend[$];
      idle_inputs();
      epoch = 6'd5;
      rst_ni = 0;
      model_reset();
      #12;
      check_all();
      @(negedge clk);
      rst_ni = 1;

      // 1: reset mid-stream
      for (int i = 0; i < 5; i++) alloc1(8'(i), 1);
      chk("t1_count5", 64'(count), 64'd5);
      rst_ni = 0;
      #2;
      model_reset();
      check_all();
      chk("t1_empty", 64'(empty), 64'd1);
      @(negedge clk);
      rst_ni = 1;
      chk("t1_rid0", 64'(alloc_rid), 64'd0);
      alloc1(8'd9, 1);
      chk("t1_count1", 64'(count), 64'd1);

      // 2: in-order retire, one edge after writeback
      flush1();
      alloc1(8'd1, 1); alloc1(8'd2, 1); alloc1(8'd3, 1);
      wb1(4'd0, 64'h11, 0, 0);
      chk("t2_nocmt_yet", 64'(cmt_v), 64'd0);
      idle1();
      chk("t2_cmt_v", 64'(cmt_v), 64'd1);
      chk("t2_rf_we", 64'(rf_we), 64'd1);
      chk("t2_Rt", 64'(rf_Rt), 64'd1);
      chk("t2_res", rf_res, 64'h11);
      chk("t2_count", 64'(count), 64'd2);

      // 3: out-of-order writebacks, back-to-back retires
      flush1();
      alloc1(8'd4, 1); alloc1(8'd5, 1); alloc1(8'd6, 1);
      wb1(4'd2, 64'h22, 0, 0);
      wb1(4'd1, 64'h21, 0, 0);
      wb1(4'd0, 64'h20, 0, 0);
      for (int i = 0; i < 3; i++) begin
         idle1();
         chk("t3_cmt_v", 64'(cmt_v), 64'd1);
         chk("t3_rid", 64'(cmt_rid), 64'(i));
      end
      idle1();
      chk("t3_done", 64'(cmt_v), 64'd0);

      // 4: full and wrap
      flush1();
      for (int i = 0; i < 16; i++) alloc1(8'(i), 1);
      chk("t4_full", 64'(full), 64'd1);
      chk("t4_rdy", 64'(alloc_rdy), 64'd0);
      alloc1(8'hAA, 1);
      chk("t4_17th", 64'(count), 64'd16);
      wb1(4'd0, 64'h40, 0, 0);
      alloc1(8'hBB, 1);
      chk("t4_cmt_blocked_alloc", 64'(count), 64'd15);
      chk("t4_reuse_rid", 64'(alloc_rid), 64'd0);
      alloc1(8'hCC, 1);
      chk("t4_count16", 64'(count), 64'd16);

      // 5: illegal instruction at retire flushes younger entries
      flush1();
      alloc1(8'd1, 1); alloc1(8'd2, 1); alloc1(8'd3, 1);
      wb1(4'd1, 64'h51, 1, 0);
      wb1(4'd0, 64'h50, 0, 0);
      wb1(4'd2, 64'h52, 0, 0);
      chk("t5_rid0", 64'(cmt_rid), 64'd0);
      chk("t5_rid0_we", 64'(rf_we), 64'd1);
      idle1();
      chk("t5_exc", 64'(exc), 64'd1);
      chk("t5_cause", 64'(exc_cause), 64'h37);
      chk("t5_we0", 64'(rf_we), 64'd0);
      chk("t5_count", 64'(count), 64'd0);
      for (int i = 0; i < 2; i++) begin
         idle1();
         chk("t5_no_rid2", 64'(cmt_v), 64'd0);
      end

      // 6: stale epoch ignored, flush beats alloc
      flush1();
      alloc1(8'd7, 1);
      wb1(4'd0, 64'h60, 0, 1);
      for (int i = 0; i < 2; i++) begin
         idle1();
         chk("t6_stale", 64'(cmt_v), 64'd0);
      end
      chk("t6_count1", 64'(count), 64'd1);
      idle_inputs();
      flush = 1; alloc_v = 1; alloc_Rt = 8'd8;
      cycle();
      chk("t6_flush_alloc", 64'(count), 64'd0);
      chk("t6_empty", 64'(empty), 64'd1);

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         idle_inputs();
         if ($urandom_range(0, 31) == 0) epoch = 6'($urandom);
         alloc_v = ($urandom_range(0, 2) != 0);
         alloc_ip = $urandom; alloc_Rt = 8'($urandom); alloc_rfwr = 1'($urandom);
         pend.delete();
         for (int j = 0; j < mq.size(); j++) if (!mq[j].done) pend.push_back(j);
         if ($urandom_range(0, 3) != 0) begin
            wb_v = 1;
            if (pend.size() > 0 && $urandom_range(0, 5) != 0)
               wb.rid = mq[pend[$urandom_range(0, pend.size() - 1)]].rid;
            else
               wb.rid = 4'($urandom);
            wb.res = {$urandom, $urandom};
            wb.epoch = ($urandom_range(0, 9) == 0) ? 6'($urandom) : epoch;
            wb_ii = ($urandom_range(0, 49) == 0);
            wb_cause = ($urandom_range(0, 49) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0;
            wb_jump = 1'($urandom); wb_branch = 1'($urandom); wb_takb = 1'($urandom);
            wb_jump_tgt = {$urandom, $urandom};
         end
         flush = ($urandom_range(0, 79) == 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
